rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter that shares one param_mux-based datapath port among N_REQ requesters.
//  It grants exactly one requester at a time and drives the mux select (sel) to that owner.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/rr_mux_arbiter.sv | 108 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Wrap-around increment: the index after idx, modulo n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first unmasked request at or after ptr, wrapping to the low indices.
// Purely combinational, no latency, no flow control.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] cand;
    int               j;

    assign cand = req & ~mask;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && cand[j]) begin
                found = 1'b1;
                idx   = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter for a shared mux port, with a hold limit that pre-empts a hogging owner.
// Grant appears one cycle after request; a released or pre-empted grant moves to the next requester on the same edge.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int SEL_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [N_REQ-1:0]  pick_mask;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [SEL_W-1:0]  pick_next;
    logic              owner_req;
    logic              at_limit;

    assign owner_req = req[sel];
    assign at_limit  = (hold_cnt == HOLD_LAST);
    assign pick_next = SEL_W'(rr_next(int'(pick_idx), N_REQ));

    // Only a limit pre-emption excludes the owner; on release its req is already low.
    always_comb begin
        pick_mask = '0;
        if (state == BUSY && owner_req && at_limit) begin
            pick_mask[sel] = 1'b1;
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= BUSY;
                        sel      <= pick_idx;
                        ptr      <= pick_next;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        hold_cnt <= '0;
                        if (pick_found) begin
                            sel <= pick_idx;
                            ptr <= pick_next;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (at_limit) begin
                        hold_cnt <= '0;
                        if (pick_found) begin
                            sel     <= pick_idx;
                            ptr     <= pick_next;
                            timeout <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant is a decode of the registered owner index, so it is one-hot by construction.
    always_comb begin
        grant = '0;
        if (state == BUSY) begin
            grant[sel] = 1'b1;
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized and directed bench for rr_mux_arbiter against a queue-free behavioural ownership model.
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    // Model: owner (-1 = none), search start, cycles the current grant has been visible.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_sel   = 0;
    int m_to    = 0;

    rr_mux_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_choose(input logic [3:0] r);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - m_ptr + N) % N) < bestd) begin
                bestd = (i - m_ptr + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic void grant_to(input int w);
        m_owner = w;
        m_sel   = w;
        m_held  = 1;
        m_ptr   = (w + 1) % N;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_sel   = 0;
        m_to    = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        int w;
        m_to = 0;
        if (m_owner < 0) begin
            w = rr_choose(r);
            if (w >= 0) grant_to(w);
        end else if (!r[m_owner]) begin
            w = rr_choose(r);
            if (w >= 0) grant_to(w);
            else m_owner = -1;
        end else if (m_held == MH) begin
            w = rr_choose(r & ~(4'b0001 << m_owner));
            if (w >= 0) begin
                grant_to(w);
                m_to = 1;
            end else begin
                m_held = 1;
            end
        end else begin
            m_held++;
        end
    endfunction

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    endfunction

    task automatic check_outputs(input string tag);
        int gi;
        check({tag, ".grant"},   int'(grant), int'(exp_grant()));
        check({tag, ".sel"},     int'(sel), m_sel);
        check({tag, ".busy"},    int'(busy), (m_owner >= 0) ? 1 : 0);
        check({tag, ".timeout"}, int'(timeout), m_to);
        check({tag, ".onehot"},  int'($onehot0(grant)), 1);
        check({tag, ".busy_or"}, int'(busy), int'(|grant));
        if (busy) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (grant[i]) gi = i;
            check({tag, ".sel_idx"}, int'(sel), gi);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear before the next edge.
    task automatic apply_reset(input logic [3:0] r, input string tag);
        #2;
        reset = 1'b1;
        req   = r;
        #1;
        model_reset();
        check({tag, ".rst_grant"}, int'(grant), 0);
        check({tag, ".rst_busy"},  int'(busy), 0);
        check({tag, ".rst_sel"},   int'(sel), 0);
        check({tag, ".rst_to"},    int'(timeout), 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".rst_hold_grant"}, int'(grant), 0);
        check({tag, ".rst_hold_busy"},  int'(busy), 0);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        int         cnt;
        int         to_cnt;

        @(negedge clk);

        // 1: reset with everyone requesting, then lowest index wins.
        apply_reset(4'b1111, "t1");
        cycle(4'b1111, "t1");
        check("t1.first_grant", int'(grant), 1);
        check("t1.first_sel", int'(sel), 0);

        // 2: owners drop one cycle after grant; ownership ping-pongs with no idle gap.
        apply_reset(4'b0000, "t2");
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1010 & ~exp_grant(), "t2");
            check("t2.seq", int'(grant), (i % 2 == 0) ? 2 : 8);
        end

        // 3: lone long holder never times out.
        apply_reset(4'b0000, "t3");
        to_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(4'b0100, "t3");
            check("t3.grant", int'(grant), 4);
            if (timeout) to_cnt++;
        end
        check("t3.timeouts", to_cnt, 0);

        // 4: hold limit pre-empts req[0] in favour of req[3] after exactly MH cycles.
        apply_reset(4'b0000, "t4");
        cycle(4'b1001, "t4");
        cnt    = (grant == 4'b0001) ? 1 : 0;
        to_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(4'b1001, "t4");
            if (timeout) to_cnt++;
            if (grant != 4'b0001) break;
            cnt++;
        end
        check("t4.hold_cycles", cnt, MH);
        check("t4.after", int'(grant), 8);
        check("t4.timeouts", to_cnt, 1);

        // 5: one-cycle pulse, back to idle, then wrap-around pick.
        apply_reset(4'b0000, "t5");
        cycle(4'b0010, "t5");
        check("t5.pulse", int'(grant), 2);
        cycle(4'b0000, "t5");
        check("t5.idle", int'(busy), 0);
        check("t5.sel_kept", int'(sel), 1);
        cycle(4'b0011, "t5");
        check("t5.wrap", int'(grant), 1);

        // 6: reset while busy, then re-arbitrate.
        apply_reset(4'b0000, "t6");
        cycle(4'b0100, "t6");
        check("t6.pre", int'(grant), 4);
        apply_reset(4'b0100, "t6r");
        cycle(4'b0100, "t6");
        check("t6.post", int'(grant), 4);

        // Random: each request bit toggles occasionally, with rare resets.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 499) == 0) begin
                apply_reset(r, "rnd");
            end else begin
                cycle(r, "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
